// File: rtl/audio_frame_sequencer.sv
// Ping-pong capture controller: fills two RAM banks alternately and hands full banks to the FFT.
// Define AUDIO_FRAME_SEQ_OVF_CNT_EN to add the saturating ovf_count port and counter.
module audio_frame_sequencer #(
  parameter int SAMPLE_W = 24,
  parameter int LOG2_N   = 9,
  parameter int OVF_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                enable,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [LOG2_N-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                frame_valid,
  output logic                frame_bank,
  input  logic                frame_ready,
  input  logic                frame_done,
`ifdef AUDIO_FRAME_SEQ_OVF_CNT_EN
  output logic [OVF_W-1:0]    ovf_count,
`endif
  output logic                overflow
);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2,
    ST_BUSY = 2'd3
  } bank_st_e;

  localparam logic [LOG2_N-1:0] LAST_ADDR = '1;

  bank_st_e          r_st [2];
  bank_st_e          w_st_nxt [2];
  logic [LOG2_N-1:0] r_wptr;
  logic [LOG2_N-1:0] w_wptr_nxt;
  logic              r_rd_next;
  logic              w_rd_nxt;

  logic w_cap;
  logic w_fill_any;
  logic w_fill_bank;
  logic w_wr;
  logic w_last;
  logic w_drop;
  logic w_acc;
  logic w_done_bank;
  logic w_done_hit;
  logic w_fv_nxt;

  assign w_cap       = advance && enable;
  assign w_fill_any  = (r_st[0] == ST_FILL) || (r_st[1] == ST_FILL);
  assign w_fill_bank = (r_st[1] == ST_FILL);
  assign w_wr        = w_cap && w_fill_any;
  assign w_last      = w_wr && (r_wptr == LAST_ADDR);
  assign w_drop      = w_cap && !w_fill_any;
  assign w_acc       = frame_valid && frame_ready;
  // Prefer rd_next when it is BUSY so that, if both ever end up BUSY, the older one is released.
  assign w_done_bank = (r_st[r_rd_next] == ST_BUSY) ? r_rd_next : ~r_rd_next;
  assign w_done_hit  = frame_done && (r_st[w_done_bank] == ST_BUSY);

  // Bank state, write pointer and read-order register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st[0]   <= ST_FILL;
      r_st[1]   <= ST_FREE;
      r_wptr    <= '0;
      r_rd_next <= 1'b0;
    end else begin
      r_st[0]   <= w_st_nxt[0];
      r_st[1]   <= w_st_nxt[1];
      r_wptr    <= w_wptr_nxt;
      r_rd_next <= w_rd_nxt;
    end
  end

  // Next-state: write, handshake and release touch banks in distinct states, so they never collide.
  always_comb begin
    w_st_nxt[0] = r_st[0];
    w_st_nxt[1] = r_st[1];
    w_wptr_nxt  = r_wptr;
    w_rd_nxt    = r_rd_next;
    if (w_last) begin
      w_st_nxt[w_fill_bank] = ST_FULL;
      w_wptr_nxt            = '0;
    end else if (w_wr) begin
      w_wptr_nxt = r_wptr + LOG2_N'(1);
    end else begin
      w_wptr_nxt = r_wptr;
    end
    if (w_acc) begin
      w_st_nxt[r_rd_next] = ST_BUSY;
      w_rd_nxt            = ~r_rd_next;
    end else begin
      w_rd_nxt = r_rd_next;
    end
    if (w_done_hit) begin
      w_st_nxt[w_done_bank] = ST_FREE;
    end else begin
      w_st_nxt[w_done_bank] = w_st_nxt[w_done_bank];
    end
    // Whenever no bank would be filling, a free bank takes over immediately (stall exit included).
    if ((w_st_nxt[0] != ST_FILL) && (w_st_nxt[1] != ST_FILL)) begin
      if (w_st_nxt[0] == ST_FREE) begin
        w_st_nxt[0] = ST_FILL;
      end else if (w_st_nxt[1] == ST_FREE) begin
        w_st_nxt[1] = ST_FILL;
      end else begin
        w_st_nxt[1] = w_st_nxt[1];
      end
    end else begin
      w_st_nxt[0] = w_st_nxt[0];
    end
  end

  // Offer a bank only once it has been FULL for a cycle; a fresh offer waits until the other bank is not BUSY.
  always_comb begin
    w_fv_nxt = (r_st[w_rd_nxt] == ST_FULL) && (w_st_nxt[w_rd_nxt] == ST_FULL) &&
               (frame_valid || (r_st[~w_rd_nxt] != ST_BUSY));
  end

  // Registered RAM write port and frame presentation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en       <= 1'b0;
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_valid <= 1'b0;
      frame_bank  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_en       <= w_wr;
      if (w_wr) begin
        wr_bank <= w_fill_bank;
        wr_addr <= r_wptr;
        wr_data <= sample_in;
      end
      frame_valid <= w_fv_nxt;
      frame_bank  <= w_rd_nxt;
      overflow    <= overflow | w_drop;
    end
  end

`ifdef AUDIO_FRAME_SEQ_OVF_CNT_EN
  // Dropped-sample counter, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_count <= '0;
    end else if (w_drop && (ovf_count != {OVF_W{1'b1}})) begin
      ovf_count <= ovf_count + OVF_W'(1);
    end else begin
      ovf_count <= ovf_count;
    end
  end
`endif

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed bench for audio_frame_sequencer with N=8; all expectations are hand-derived constants.
module tb_audio_frame_sequencer;

  localparam int SAMPLE_W = 24;
  localparam int LOG2_N   = 3;
  localparam int OVF_W    = 16;

  logic                clk;
  logic                reset;
  logic                advance;
  logic [SAMPLE_W-1:0] sample_in;
  logic                enable;
  logic                wr_en;
  logic                wr_bank;
  logic [LOG2_N-1:0]   wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic                frame_valid;
  logic                frame_bank;
  logic                frame_ready;
  logic                frame_done;
  logic                overflow;
`ifdef AUDIO_FRAME_SEQ_OVF_CNT_EN
  logic [OVF_W-1:0]    ovf_count;
`endif

  int n_checks;
  int n_errors;

  audio_frame_sequencer #(
    .SAMPLE_W(SAMPLE_W),
    .LOG2_N  (LOG2_N),
    .OVF_W   (OVF_W)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .advance    (advance),
    .sample_in  (sample_in),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_valid(frame_valid),
    .frame_bank (frame_bank),
    .frame_ready(frame_ready),
    .frame_done (frame_done),
`ifdef AUDIO_FRAME_SEQ_OVF_CNT_EN
    .ovf_count  (ovf_count),
`endif
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input logic [SAMPLE_W-1:0] s);
    advance   = 1'b1;
    sample_in = s;
    step();
    advance   = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic bank, input logic [LOG2_N-1:0] addr,
                          input logic [SAMPLE_W-1:0] data);
    check_val({tag, "_wr_en"}, 32'(wr_en), 32'd1);
    check_val({tag, "_wr_bank"}, 32'(wr_bank), 32'(bank));
    check_val({tag, "_wr_addr"}, 32'(wr_addr), 32'(addr));
    check_val({tag, "_wr_data"}, 32'(wr_data), 32'(data));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check_val({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
    check_val({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check_val({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check_val({tag, "_fvalid"}, 32'(frame_valid), 32'd0);
    check_val({tag, "_fbank"}, 32'(frame_bank), 32'd0);
    check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
`ifdef AUDIO_FRAME_SEQ_OVF_CNT_EN
    check_val({tag, "_ovfcnt"}, 32'(ovf_count), 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    advance     = 1'b0;
    sample_in   = '0;
    enable      = 1'b1;
    frame_ready = 1'b0;
    frame_done  = 1'b0;

    // Reset state, then fill bank0 with ready held low.
    do_reset();
    check_idle_outputs("rst");
    for (int i = 0; i < 8; i++) begin
      adv(SAMPLE_W'(i + 1));
      check_wr($sformatf("fill%0d", i), 1'b0, LOG2_N'(i), SAMPLE_W'(i + 1));
    end
    check_val("fill_fv_early", 32'(frame_valid), 32'd0);
    adv(24'h000009);
    check_wr("fill9", 1'b1, 3'd0, 24'h000009);
    check_val("fill_fv", 32'(frame_valid), 32'd1);
    check_val("fill_fbank", 32'(frame_bank), 32'd0);

    // Offer must hold while the FFT is not ready.
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("hold_fv", 32'(frame_valid), 32'd1);
      check_val("hold_fbank", 32'(frame_bank), 32'd0);
    end
    check_val("hold_wr_en", 32'(wr_en), 32'd0);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    check_val("hs_fv_drop", 32'(frame_valid), 32'd0);

    // Overflow: bank0 BUSY, bank1 FULL, 17th sample dropped.
    do_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < 16; i++) adv(SAMPLE_W'(i + 16'h100));
    check_wr("ovf16", 1'b1, 3'd7, 24'h00010f);
    check_val("ovf16_flag", 32'(overflow), 32'd0);
    adv(24'h000aaa);
    check_val("ovf17_wr_en", 32'(wr_en), 32'd0);
    check_val("ovf17_flag", 32'(overflow), 32'd1);
    check_val("ovf17_fv", 32'(frame_valid), 32'd0);
`ifdef AUDIO_FRAME_SEQ_OVF_CNT_EN
    check_val("ovf17_cnt", 32'(ovf_count), 32'd1);
`endif
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    adv(24'h000bbb);
    check_wr("ovf_resume", 1'b0, 3'd0, 24'h000bbb);
    check_val("ovf_sticky", 32'(overflow), 32'd1);
    check_val("ovf_resume_fv", 32'(frame_valid), 32'd1);
    check_val("ovf_resume_fbank", 32'(frame_bank), 32'd1);
    step();
    check_val("ovf_pulse_wr_en", 32'(wr_en), 32'd0);

    // frame_done coincides with the last write of bank1: nothing dropped.
    do_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      frame_done = (i == 15);
      adv(SAMPLE_W'(i + 16'h200));
    end
    frame_done = 1'b0;
    check_wr("sim16", 1'b1, 3'd7, 24'h00020f);
    adv(24'h000ccc);
    check_wr("sim17", 1'b0, 3'd0, 24'h000ccc);
    check_val("sim_ovf", 32'(overflow), 32'd0);
    check_val("sim_fv", 32'(frame_valid), 32'd1);
    check_val("sim_fbank", 32'(frame_bank), 32'd1);

    // Asynchronous reset mid-fill, enable gating, then a clean refill.
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < 5; i++) adv(SAMPLE_W'(i + 16'h300));
    check_wr("mid5", 1'b0, 3'd4, 24'h000304);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("midrst");
    reset = 1'b1;
    step();
    enable = 1'b0;
    adv(24'h000ddd);
    check_val("en_low_wr_en", 32'(wr_en), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      adv(SAMPLE_W'(i + 16'h400));
      check_wr($sformatf("refill%0d", i), 1'b0, LOG2_N'(i), SAMPLE_W'(i + 16'h400));
    end
    step();
    check_val("refill_fv", 32'(frame_valid), 32'd1);
    check_val("refill_fbank", 32'(frame_bank), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
